// File: rtl/trap_controller.sv
// Machine-mode trap entry / mret sequencer: drives the CSR file's implicit
// read and write slots, owns the privilege mode and issues the fetch redirect.
module trap_controller #(
  parameter logic [1:0] RESET_MODE  = 2'd3,
  parameter bit         VECTORED_EN = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         exc_valid,
  input  logic [4:0]   exc_cause,
  input  logic [31:0]  exc_pc,
  input  logic [31:0]  exc_tval,
  input  logic         mret_valid,
  input  logic         irq_valid,
  input  logic [4:0]   irq_cause,
  input  logic [31:0]  irq_pc,
  output logic         accept,
  output logic         busy,
  output logic [1:0]   mode,
  output logic [47:0]  impl_addrs_r,
  output logic [3:0]   impl_read_enable,
  input  logic [127:0] impl_csr,
  output logic [47:0]  impl_addrs_w,
  output logic [3:0]   impl_write_enable,
  output logic [127:0] impl_write_data,
  output logic         redirect_valid,
  output logic [31:0]  redirect_pc
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 12;
  localparam int unsigned CW   = 5;

  localparam logic [AW-1:0] CSR_MSTATUS = 12'h300;
  localparam logic [AW-1:0] CSR_MIE     = 12'h304;
  localparam logic [AW-1:0] CSR_MTVEC   = 12'h305;
  localparam logic [AW-1:0] CSR_MEPC    = 12'h341;
  localparam logic [AW-1:0] CSR_MCAUSE  = 12'h342;
  localparam logic [AW-1:0] CSR_MTVAL   = 12'h343;
  localparam logic [1:0]    MODE_M      = 2'd3;

  typedef enum logic [1:0] {IDLE, READ, WRITE, REDIRECT} state_t;

  state_t          state_q, state_d;
  logic            is_irq_q, is_irq_d;
  logic            is_mret_q, is_mret_d;
  logic [CW-1:0]   cause_q, cause_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] tval_q, tval_d;
  logic [XLEN-1:0] mstatus_q, mstatus_d;
  logic [XLEN-1:0] vec_q, vec_d;       // mtvec for traps, mepc for mret
  logic [1:0]      mode_d;

  logic [XLEN-1:0] rd_mstatus, rd_slot1, rd_mie;
  logic [XLEN-1:0] ms_trap, ms_mret, base, target;
  logic [1:0]      mpp;
  logic            irq_taken;
  logic            unused_csr;

  assign rd_mstatus = impl_csr[31:0];
  assign rd_slot1   = impl_csr[63:32];
  assign rd_mie     = impl_csr[95:64];
  assign unused_csr = ^impl_csr[127:96];

  // State register and trap-frame latches
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      mode      <= RESET_MODE;
      is_irq_q  <= 1'b0;
      is_mret_q <= 1'b0;
      cause_q   <= '0;
      pc_q      <= '0;
      tval_q    <= '0;
      mstatus_q <= '0;
      vec_q     <= '0;
    end else begin
      state_q   <= state_d;
      mode      <= mode_d;
      is_irq_q  <= is_irq_d;
      is_mret_q <= is_mret_d;
      cause_q   <= cause_d;
      pc_q      <= pc_d;
      tval_q    <= tval_d;
      mstatus_q <= mstatus_d;
      vec_q     <= vec_d;
    end
  end

  // Next-state, latch updates and slot/redirect outputs
  always_comb begin
    state_d           = state_q;
    mode_d            = mode;
    is_irq_d          = is_irq_q;
    is_mret_d         = is_mret_q;
    cause_d           = cause_q;
    pc_d              = pc_q;
    tval_d            = tval_q;
    mstatus_d         = mstatus_q;
    vec_d             = vec_q;
    accept            = 1'b0;
    busy              = (state_q != IDLE);
    impl_addrs_r      = '0;
    impl_read_enable  = '0;
    impl_addrs_w      = '0;
    impl_write_enable = '0;
    impl_write_data   = '0;
    redirect_valid    = 1'b0;
    redirect_pc       = '0;

    ms_trap         = mstatus_q;
    ms_trap[7]      = mstatus_q[3];
    ms_trap[3]      = 1'b0;
    ms_trap[12:11]  = mode;
    ms_mret         = mstatus_q;
    ms_mret[3]      = mstatus_q[7];
    ms_mret[7]      = 1'b1;
    ms_mret[12:11]  = 2'b00;
    // Reserved MPP encoding 2 returns to user mode
    mpp       = (mstatus_q[12:11] == 2'd2) ? 2'd0 : mstatus_q[12:11];
    base      = {vec_q[31:2], 2'b00};
    target    = base;
    if (VECTORED_EN && is_irq_q && !is_mret_q && (vec_q[1:0] == 2'b01))
      target = base + XLEN'({cause_q, 2'b00});
    irq_taken = rd_mie[cause_q] && (rd_mstatus[3] || (mode != MODE_M));

    case (state_q)
      IDLE: begin
        if (exc_valid) begin
          accept    = 1'b1;
          is_irq_d  = 1'b0;
          is_mret_d = 1'b0;
          cause_d   = exc_cause;
          pc_d      = exc_pc;
          tval_d    = exc_tval;
          state_d   = READ;
        end else if (mret_valid) begin
          accept    = 1'b1;
          is_irq_d  = 1'b0;
          is_mret_d = 1'b1;
          cause_d   = '0;
          pc_d      = '0;
          tval_d    = '0;
          state_d   = READ;
        end else if (irq_valid) begin
          accept    = 1'b1;
          is_irq_d  = 1'b1;
          is_mret_d = 1'b0;
          cause_d   = irq_cause;
          pc_d      = irq_pc;
          tval_d    = '0;
          state_d   = READ;
        end
      end
      READ: begin
        impl_read_enable = 4'b0111;
        impl_addrs_r     = {AW'(0), (is_mret_q ? AW'(0) : CSR_MIE),
                            (is_mret_q ? CSR_MEPC : CSR_MTVEC), CSR_MSTATUS};
        mstatus_d        = rd_mstatus;
        vec_d            = rd_slot1;
        state_d          = (is_irq_q && !irq_taken) ? IDLE : WRITE;
      end
      WRITE: begin
        if (is_mret_q) begin
          impl_write_enable = 4'b0001;
          impl_addrs_w      = {3'b000 * AW'(0), AW'(0), AW'(0), CSR_MSTATUS};
          impl_write_data   = {96'h0, ms_mret};
        end else begin
          impl_write_enable = 4'b1111;
          impl_addrs_w      = {CSR_MSTATUS, CSR_MTVAL, CSR_MCAUSE, CSR_MEPC};
          impl_write_data   = {ms_trap, tval_q, {is_irq_q, 26'b0, cause_q}, pc_q};
        end
        state_d = REDIRECT;
      end
      REDIRECT: begin
        redirect_valid = 1'b1;
        redirect_pc    = target;
        mode_d         = is_mret_q ? mpp : MODE_M;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_trap_controller.sv
// Self-checking bench for trap_controller: directed scenarios plus randomized
// traps/mrets against a behavioural model of the trap rules.
module tb_trap_controller;

  localparam logic [1:0] RESET_MODE  = 2'd3;
  localparam bit         VECTORED_EN = 1'b1;

  logic         clk = 1'b0;
  logic         reset;
  logic         exc_valid, mret_valid, irq_valid;
  logic [4:0]   exc_cause, irq_cause;
  logic [31:0]  exc_pc, exc_tval, irq_pc;
  logic         accept, busy, redirect_valid;
  logic [1:0]   mode;
  logic [47:0]  impl_addrs_r, impl_addrs_w;
  logic [3:0]   impl_read_enable, impl_write_enable;
  logic [127:0] impl_csr, impl_write_data;
  logic [31:0]  redirect_pc;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [31:0] csr_mstatus, csr_mtvec, csr_mie, csr_mepc;
  logic [1:0]  exp_mode;

  trap_controller #(.RESET_MODE(RESET_MODE), .VECTORED_EN(VECTORED_EN)) dut (
    .clk(clk), .reset(reset),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc), .exc_tval(exc_tval),
    .mret_valid(mret_valid), .irq_valid(irq_valid), .irq_cause(irq_cause), .irq_pc(irq_pc),
    .accept(accept), .busy(busy), .mode(mode),
    .impl_addrs_r(impl_addrs_r), .impl_read_enable(impl_read_enable), .impl_csr(impl_csr),
    .impl_addrs_w(impl_addrs_w), .impl_write_enable(impl_write_enable),
    .impl_write_data(impl_write_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  // Behavioural CSR file: combinational read ports
  always_comb begin
    impl_csr = '0;
    for (int i = 0; i < 4; i++) begin
      if (impl_read_enable[i]) begin
        case (impl_addrs_r[12*i +: 12])
          12'h300: impl_csr[32*i +: 32] = csr_mstatus;
          12'h304: impl_csr[32*i +: 32] = csr_mie;
          12'h305: impl_csr[32*i +: 32] = csr_mtvec;
          12'h341: impl_csr[32*i +: 32] = csr_mepc;
          default: impl_csr[32*i +: 32] = 32'h0;
        endcase
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got no finish, want finish");
    $fatal(1);
  end

  // kind: 0 = exception, 1 = mret, 2 = interrupt; hold keeps losing requests up while busy
  task automatic run_txn(input int kind, input logic [4:0] cause, input logic [31:0] pc,
                         input logic [31:0] tval, input bit hold);
    logic [31:0] ms, w_ms, w_cause, w_tval, tgt;
    logic [1:0]  new_mode;
    bit          irq, taken;
    ms  = csr_mstatus;
    irq = (kind == 2);
    if (kind == 1) begin
      taken    = 1'b1;
      w_ms     = (ms & ~32'h1888) | (ms[7] ? 32'h8 : 32'h0) | 32'h80;
      tgt      = csr_mepc & ~32'h3;
      new_mode = (ms[12:11] == 2'd2) ? 2'd0 : ms[12:11];
      w_cause  = 32'h0;
      w_tval   = 32'h0;
    end else begin
      taken    = !irq || (csr_mie[cause] && (ms[3] || exp_mode != 2'd3));
      w_ms     = (ms & ~32'h1888) | (ms[3] ? 32'h80 : 32'h0) | ({30'b0, exp_mode} << 11);
      w_cause  = {irq, 26'b0, cause};
      w_tval   = irq ? 32'h0 : tval;
      tgt      = csr_mtvec & ~32'h3;
      if (VECTORED_EN && irq && csr_mtvec[1:0] == 2'b01) tgt = tgt + 32'(cause) * 4;
      new_mode = 2'd3;
    end

    @(negedge clk);
    exc_valid  = (kind == 0);
    mret_valid = (kind == 1) || (hold && kind == 0);
    irq_valid  = (kind == 2) || (hold && kind < 2);
    exc_cause  = (kind == 0) ? cause : 5'($urandom);
    exc_pc     = (kind == 0) ? pc : $urandom;
    exc_tval   = tval;
    irq_cause  = (kind == 2) ? cause : 5'($urandom);
    irq_pc     = (kind == 2) ? pc : $urandom;
    #1;
    n_cmp++; if (accept !== 1'b1) begin n_bad++; $display("FAIL accept_T: got %b want 1 (kind %0d)", accept, kind); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL busy_T: got %b want 0", busy); end

    @(negedge clk);
    exc_valid = 1'b0;
    if (kind == 1 || !hold) mret_valid = 1'b0;
    if (kind == 2 || !hold) irq_valid = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b1 || accept !== 1'b0) begin n_bad++; $display("FAIL read_busy: got busy %b accept %b want 1 0", busy, accept); end
    n_cmp++; if (impl_read_enable !== 4'b0111) begin n_bad++; $display("FAIL read_en: got %b want 0111", impl_read_enable); end
    n_cmp++; if (impl_addrs_r[23:0] !== ((kind == 1) ? 24'h341300 : 24'h305300)) begin n_bad++; $display("FAIL read_addr: got %h want slot0/1 for kind %0d", impl_addrs_r, kind); end

    @(negedge clk); #1;
    if (!taken) begin
      n_cmp++; if (impl_write_enable !== 4'b0 || busy !== 1'b0 || redirect_valid !== 1'b0) begin n_bad++; $display("FAIL irq_masked: got we %b busy %b rv %b want 0 0 0", impl_write_enable, busy, redirect_valid); end
      @(negedge clk); #1;
      n_cmp++; if (impl_write_enable !== 4'b0 || redirect_valid !== 1'b0) begin n_bad++; $display("FAIL irq_masked2: got we %b rv %b want 0 0", impl_write_enable, redirect_valid); end
      n_cmp++; if (mode !== exp_mode) begin n_bad++; $display("FAIL irq_masked_mode: got %0d want %0d", mode, exp_mode); end
      exc_valid = 1'b0; mret_valid = 1'b0; irq_valid = 1'b0;
      return;
    end
    n_cmp++; if (busy !== 1'b1 || accept !== 1'b0) begin n_bad++; $display("FAIL write_busy: got busy %b accept %b want 1 0", busy, accept); end
    if (kind == 1) begin
      n_cmp++; if (impl_write_enable !== 4'b0001 || impl_addrs_w[11:0] !== 12'h300 || impl_write_data[31:0] !== w_ms) begin
        n_bad++; $display("FAIL mret_write: got we %b addr %h data %h want 0001 300 %h", impl_write_enable, impl_addrs_w[11:0], impl_write_data[31:0], w_ms);
      end
    end else begin
      n_cmp++; if (impl_write_enable !== 4'b1111 || impl_addrs_w !== 48'h300343342341) begin
        n_bad++; $display("FAIL trap_wr_addr: got we %b addr %h want 1111 300343342341", impl_write_enable, impl_addrs_w);
      end
      n_cmp++; if (impl_write_data !== {w_ms, w_tval, w_cause, pc}) begin
        n_bad++; $display("FAIL trap_wr_data: got %h want %h", impl_write_data, {w_ms, w_tval, w_cause, pc});
      end
    end

    @(negedge clk);
    exc_valid = 1'b0; mret_valid = 1'b0; irq_valid = 1'b0;
    #1;
    n_cmp++; if (redirect_valid !== 1'b1 || redirect_pc !== tgt) begin n_bad++; $display("FAIL redirect: got v %b pc %h want 1 %h", redirect_valid, redirect_pc, tgt); end
    n_cmp++; if (mode !== exp_mode || impl_write_enable !== 4'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL redirect_side: got mode %0d we %b busy %b want %0d 0 1", mode, impl_write_enable, busy, exp_mode); end

    @(negedge clk); #1;
    n_cmp++; if (mode !== new_mode) begin n_bad++; $display("FAIL new_mode: got %0d want %0d", mode, new_mode); end
    n_cmp++; if (busy !== 1'b0 || redirect_valid !== 1'b0 || accept !== 1'b0) begin n_bad++; $display("FAIL post_idle: got busy %b rv %b acc %b want 0 0 0", busy, redirect_valid, accept); end
    exp_mode = new_mode;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    exc_valid = 1'b0; mret_valid = 1'b0; irq_valid = 1'b0;
    exc_cause = '0; exc_pc = '0; exc_tval = '0; irq_cause = '0; irq_pc = '0;
    csr_mstatus = '0; csr_mtvec = '0; csr_mie = '0; csr_mepc = '0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (mode !== RESET_MODE) begin n_bad++; $display("FAIL reset_mode: got %0d want %0d", mode, RESET_MODE); end
    n_cmp++; if (busy !== 1'b0 || accept !== 1'b0 || redirect_valid !== 1'b0 || redirect_pc !== 32'h0) begin n_bad++; $display("FAIL reset_ctl: got busy %b acc %b rv %b pc %h want zeros", busy, accept, redirect_valid, redirect_pc); end
    n_cmp++; if (impl_read_enable !== 4'b0 || impl_write_enable !== 4'b0 || impl_addrs_r !== 48'h0 || impl_addrs_w !== 48'h0 || impl_write_data !== 128'h0) begin n_bad++; $display("FAIL reset_slots: got re %b we %b want 0 0", impl_read_enable, impl_write_enable); end
    @(negedge clk);
    reset = 1'b1;
    exp_mode = RESET_MODE;
  endtask

  task automatic test_mret_to_user();
    csr_mstatus = 32'h0; csr_mepc = 32'h40;
    run_txn(1, 5'd0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic test_exc_user();
    csr_mstatus = 32'h8; csr_mtvec = 32'h100;
    run_txn(0, 5'd2, 32'h40, 32'hDEAD, 1'b0);
  endtask

  task automatic test_vectored_irq();
    csr_mstatus = 32'h8; csr_mie = 32'h800; csr_mtvec = 32'h201;
    run_txn(2, 5'd11, 32'h1000, 32'h0, 1'b0);
  endtask

  task automatic test_masked_irq();
    int acc;
    acc = 0;
    csr_mstatus = 32'h0; csr_mie = 32'hFFFF_FFFF;
    @(negedge clk);
    irq_valid = 1'b1; irq_cause = 5'd7; irq_pc = 32'h2000;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (accept === 1'b1) acc++;
      n_cmp++; if (impl_write_enable !== 4'b0 || redirect_valid !== 1'b0) begin n_bad++; $display("FAIL masked_cycle%0d: got we %b rv %b want 0 0", i, impl_write_enable, redirect_valid); end
      @(negedge clk);
    end
    irq_valid = 1'b0;
    n_cmp++; if (acc != 6) begin n_bad++; $display("FAIL masked_reeval: got %0d accepts want 6", acc); end
    @(negedge clk); #1;
    n_cmp++; if (busy !== 1'b0 || mode !== exp_mode) begin n_bad++; $display("FAIL masked_end: got busy %b mode %0d want 0 %0d", busy, mode, exp_mode); end
  endtask

  task automatic test_mret();
    csr_mstatus = 32'h80; csr_mepc = 32'h44;
    run_txn(1, 5'd0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic test_reset_mid();
    csr_mstatus = 32'h8; csr_mtvec = 32'h300;
    @(negedge clk);
    exc_valid = 1'b1; exc_cause = 5'd4; exc_pc = 32'h80; exc_tval = 32'h1;
    @(negedge clk);
    exc_valid = 1'b0;
    @(negedge clk); #1;
    n_cmp++; if (impl_write_enable !== 4'b1111) begin n_bad++; $display("FAIL rstmid_write: got we %b want 1111", impl_write_enable); end
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (impl_write_enable !== 4'b0 || redirect_valid !== 1'b0 || busy !== 1'b0 || mode !== RESET_MODE) begin
      n_bad++; $display("FAIL rstmid_abort: got we %b rv %b busy %b mode %0d want 0 0 0 %0d", impl_write_enable, redirect_valid, busy, mode, RESET_MODE);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk); #1;
    n_cmp++; if (redirect_valid !== 1'b0 || busy !== 1'b0 || impl_read_enable !== 4'b0) begin n_bad++; $display("FAIL rstmid_idle: got rv %b busy %b re %b want 0 0 0", redirect_valid, busy, impl_read_enable); end
    exp_mode = RESET_MODE;
  endtask

  task automatic test_back_to_back();
    csr_mstatus = 32'h0000_1888; csr_mtvec = 32'h8000_0001; csr_mie = 32'hFFFF_FFFF;
    run_txn(0, 5'd7, 32'h1234, 32'h55, 1'b1);
    csr_mstatus = 32'h0000_0880; csr_mepc = 32'h0000_0123;
    run_txn(1, 5'd0, 32'h0, 32'h0, 1'b1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      csr_mstatus = $urandom;
      csr_mtvec   = ($urandom_range(0, 1) == 1) ? ($urandom & ~32'h2) | 32'h1 : $urandom;
      csr_mie     = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : $urandom;
      csr_mepc    = $urandom;
      run_txn(int'($urandom_range(0, 2)), 5'($urandom), $urandom, $urandom,
              bit'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_mret_to_user();
    test_exc_user();
    test_vectored_irq();
    test_masked_irq();
    test_mret();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
